fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the CPU. It owns the program counter and issues word fetches to instruction memory over a req/ack handshake. Returned instructions go into a 2-entry buffer. The block drives the data and enable of the IF/ID enabled register directly downstream, so a downstream stall holds that register while fetching continues until the buffer fills. Branch/jump redirects flush the buffer and discard any in-flight response.

## Interface
- RESET_PC, default 0: fetch address loaded on reset.
- PC_STEP, default 4: byte increment between sequential fetches.
- clk  in  1: single clock, rising edge.
- clr  in  1: asynchronous, active-high reset.
- imem_req  out  1: fetch request.
- imem_addr  out  `WORDSIZE: fetch address; stable while imem_req=1 and no ack.
- imem_ack  in  1: response valid this cycle; may be high in the same cycle as the request.
- imem_rdata  in  `WORDSIZE: instruction word, valid when imem_ack=1.
- redirect  in  1: one-cycle pulse requesting a new fetch address.
- redirect_pc  in  `WORDSIZE: new fetch address, sampled when redirect=1.
- stall  in  1: downstream cannot accept an instruction.
- if_en  out  1: enable for the IF/ID register; the head entry is consumed on this edge.
- if_instr  out  `WORDSIZE: head entry instruction; 0 when the buffer is empty.
- if_pc  out  `WORDSIZE: head entry PC; 0 when the buffer is empty.

## Operation
- States:
  - IDLE: first cycle after reset.
  - FETCH: imem_req=1.
  - FULL: buffer full, imem_req=0.
  - DRAIN: waiting for a response that will be discarded.
- IDLE→FETCH unconditionally.
- FETCH on ack:
  - push {fetch_pc, imem_rdata}.
  - fetch_pc += PC_STEP, wrapping modulo 2^`WORDSIZE.
  - Go to FULL if the count after push and pop equals 2; otherwise stay in FETCH, with imem_req still high at the new address.
- FULL→FETCH when the count after pop is below 2.
- Pop: if_en = (count>0) && !stall && !redirect. A push and a pop in the same cycle leave count unchanged.
- Redirect has the highest priority:
  - Buffer is flushed (count=0); if_en=0 that cycle.
  - fetch_pc = redirect_pc.
  - In FETCH with no ack in the same cycle: go to DRAIN. imem_addr and imem_req hold the old request until its ack; that data is dropped; then go to FETCH at the new PC.
  - In FETCH with ack in the same cycle: the data is dropped and the next state is FETCH at redirect_pc.
  - In FULL or IDLE: go to FETCH at redirect_pc.
  - In DRAIN: remain in DRAIN; redirect_pc overwrites the target.
- There is never more than one request outstanding.

## Timing
- Reset values:
  - imem_req=0, imem_addr=RESET_PC.
  - if_en=0, if_instr=0, if_pc=0.
  - count=0, state IDLE.
- First imem_req=1 occurs in the second cycle after clr deasserts.
- Response to output: an instruction acked at edge N appears on if_instr/if_pc after edge N. if_en is high in that cycle unless stall or redirect is asserted.
- Throughput: with ack in the same cycle as the request and no stall, one instruction per cycle.
- If clr is asserted mid-request, the pending response is abandoned; memory must tolerate a dropped request.
- if_en, if_instr and if_pc are decoded combinationally from registered buffer state plus stall and redirect; there is no combinational path from imem_rdata.

## Structure
- defines.v holds `WORDSIZE plus new defines: fetch state encodings (2 bits) and the default PC_STEP.
- One sub-module, fetch_buf:
  - 2-entry FIFO of {pc, instr}, 2×`WORDSIZE wide.
  - Ports: push, pop, flush, count, head outputs.
  - Asynchronous clr.
- fetch_unit contains the FSM and the PC register.

## Test plan
- Reset release, ack in the same cycle, stall=0: imem_addr sequence 0,4,8,12; if_pc follows 0,4,8 one cycle later; if_en continuously 1.
- stall=1 held for 5 cycles: exactly two pushes, then FULL with imem_req=0. Release stall: if_pc 0 then 4 on consecutive cycles, and imem_req re-asserts.
- Ack delayed 3 cycles: imem_addr is held stable for 3 cycles; if_en pulses once per 4 cycles.
- redirect to 0x100 while a request to 0x8 waits for ack: on ack, 0x8 data is not presented; the next imem_addr is 0x100 and the next if_pc is 0x100.
- redirect in the same cycle as ack with the buffer holding 2 entries: if_en=0 that cycle; the buffer is empty afterwards; the next fetch is at redirect_pc.
- PC wrap: RESET_PC=2^`WORDSIZE−4; the second imem_addr is 0.
- clr asserted mid-FETCH: outputs return to reset values immediately, asynchronously.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage: word size,
// FSM state encodings, buffer entry layout and the default PC increment.
package fetch_unit_pkg;

  localparam int WORDSIZE = 32;

  localparam logic [WORDSIZE-1:0] DEFAULT_PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FULL  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [WORDSIZE-1:0] pc;
    logic [WORDSIZE-1:0] instr;
  } fetch_entry_t;

  // Sequential fetch address; plain addition wraps modulo 2^WORDSIZE.
  function automatic logic [WORDSIZE-1:0] step_pc(input logic [WORDSIZE-1:0] pc,
                                                  input logic [WORDSIZE-1:0] step);
    return pc + step;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory req/ack bus between the fetch stage (master) and
// instruction memory (slave).
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic                imem_req;
  logic [WORDSIZE-1:0] imem_addr;
  logic                imem_ack;
  logic [WORDSIZE-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_buf.sv
// Two-entry FIFO of {pc, instr} between instruction memory and the IF/ID
// register. Head reads as zero when empty; flush wins over push/pop.
module fetch_buf
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t entries [2];
  logic         rd_ptr;
  logic         wr_ptr;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      entries[0] <= '0;
      entries[1] <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        entries[wr_ptr] <= push_entry;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = (count != 2'd0) ? entries[rd_ptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding imem request at
// a time, buffers responses and presents the head to the IF/ID register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [WORDSIZE-1:0] RESET_PC = '0,
  parameter logic [WORDSIZE-1:0] PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic                clk,
  input  logic                clr,
  fetch_unit_if.master        imem,
  input  logic                redirect,
  input  logic [WORDSIZE-1:0] redirect_pc,
  input  logic                stall,
  output logic                if_en,
  output logic [WORDSIZE-1:0] if_instr,
  output logic [WORDSIZE-1:0] if_pc
);

  fetch_state_t        state;
  fetch_state_t        next_state;
  logic [WORDSIZE-1:0] fetch_pc;
  logic [WORDSIZE-1:0] drain_addr;
  logic [1:0]          count;
  logic [1:0]          count_after;
  fetch_entry_t        head;
  logic                ack;
  logic                push;
  logic                pop;

  fetch_buf u_buf (
    .clk        (clk),
    .clr        (clr),
    .push       (push),
    .pop        (pop),
    .flush      (redirect),
    .push_entry ({fetch_pc, imem.imem_rdata}),
    .count      (count),
    .head       (head)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  next_state = ST_FETCH;
      ST_FETCH: begin
        if (redirect) begin
          next_state = ack ? ST_FETCH : ST_DRAIN;
        end else if (ack && count_after == 2'd2) begin
          next_state = ST_FULL;
        end
      end
      ST_FULL: begin
        if (redirect || count_after < 2'd2) begin
          next_state = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (ack) begin
          next_state = ST_FETCH;
        end
      end
      default:  next_state = ST_IDLE;
    endcase
  end

  // In DRAIN the old request stays on the bus while fetch_pc already holds the new target.
  always_comb begin
    imem.imem_req  = (state == ST_FETCH) || (state == ST_DRAIN);
    imem.imem_addr = (state == ST_DRAIN) ? drain_addr : fetch_pc;
    ack            = imem.imem_req && imem.imem_ack;
    push           = (state == ST_FETCH) && imem.imem_ack && !redirect;
    pop            = (count != 2'd0) && !stall && !redirect;
    count_after    = count + {1'b0, push} - {1'b0, pop};
    if_en          = pop;
    if_instr       = head.instr;
    if_pc          = head.pc;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      fetch_pc   <= RESET_PC;
      drain_addr <= RESET_PC;
    end else begin
      if (redirect) begin
        fetch_pc <= redirect_pc;
      end else if (push) begin
        fetch_pc <= step_pc(fetch_pc, PC_STEP);
      end
      if (state == ST_FETCH && redirect && !ack) begin
        drain_addr <= fetch_pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stall/fill, delayed ack,
// redirects while waiting and on ack, PC wrap and asynchronous clear.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        clr;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_en;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  logic        wrap_en;
  logic [31:0] wrap_instr;
  logic [31:0] wrap_pc;
  logic        zero_bit  = 1'b0;
  logic [31:0] zero_word = 32'd0;

  int ack_delay = 0;
  int wait_cnt  = 0;
  int checks    = 0;
  int failures  = 0;

  fetch_unit_if imem ();
  fetch_unit_if wrap_imem ();

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk         (clk),
    .clr         (clr),
    .imem        (imem),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .if_en       (if_en),
    .if_instr    (if_instr),
    .if_pc       (if_pc)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk         (clk),
    .clr         (clr),
    .imem        (wrap_imem),
    .redirect    (zero_bit),
    .redirect_pc (zero_word),
    .stall       (zero_bit),
    .if_en       (wrap_en),
    .if_instr    (wrap_instr),
    .if_pc       (wrap_pc)
  );

  // Memory model: acks after ack_delay waiting cycles, data is address + 0x1000_0000.
  assign imem.imem_ack   = imem.imem_req && (wait_cnt >= ack_delay);
  assign imem.imem_rdata = imem.imem_addr + 32'h1000_0000;
  assign wrap_imem.imem_ack   = wrap_imem.imem_req;
  assign wrap_imem.imem_rdata = wrap_imem.imem_addr + 32'h1000_0000;

  always @(posedge clk) begin
    if (!imem.imem_req || imem.imem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic r, input logic [31:0] rpc);
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
  endtask

  task automatic checkFetch(input string tag, input logic exp_req, input logic [31:0] exp_addr);
    checkOutput({tag, "_req"}, {31'd0, imem.imem_req}, {31'd0, exp_req});
    checkOutput({tag, "_addr"}, imem.imem_addr, exp_addr);
  endtask

  task automatic checkHead(input string tag, input logic exp_en, input logic [31:0] exp_pc,
                           input bit empty);
    checkOutput({tag, "_en"}, {31'd0, if_en}, {31'd0, exp_en});
    checkOutput({tag, "_pc"}, if_pc, empty ? 32'd0 : exp_pc);
    checkOutput({tag, "_instr"}, if_instr, empty ? 32'd0 : exp_pc + 32'h1000_0000);
  endtask

  initial begin
    clr = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    checkFetch("rst", 1'b0, 32'd0);
    checkHead("rst", 1'b0, 32'd0, 1'b1);
    clr = 1'b0;

    // Same-cycle ack, no stall: one instruction per cycle.
    @(negedge clk);
    checkFetch("seq0", 1'b1, 32'd0);
    checkHead("seq0", 1'b0, 32'd0, 1'b1);
    checkOutput("wrap0", wrap_imem.imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    checkFetch("seq1", 1'b1, 32'd4);
    checkHead("seq1", 1'b1, 32'd0, 1'b0);
    checkOutput("wrap1", wrap_imem.imem_addr, 32'd0);
    @(negedge clk);
    checkFetch("seq2", 1'b1, 32'd8);
    checkHead("seq2", 1'b1, 32'd4, 1'b0);
    @(negedge clk);
    checkFetch("seq3", 1'b1, 32'd12);
    checkHead("seq3", 1'b1, 32'd8, 1'b0);

    // Asynchronous clear in the middle of a request.
    clr = 1'b1;
    #1;
    checkFetch("clr", 1'b0, 32'd0);
    checkHead("clr", 1'b0, 32'd0, 1'b1);
    @(negedge clk);
    clr = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'd0);

    // Stall for 5 edges: two pushes then FULL.
    @(negedge clk);
    checkFetch("stl0", 1'b1, 32'd0);
    checkHead("stl0", 1'b0, 32'd0, 1'b1);
    @(negedge clk);
    checkFetch("stl1", 1'b1, 32'd4);
    checkHead("stl1", 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    checkFetch("stl2", 1'b0, 32'd8);
    checkHead("stl2", 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    checkFetch("stl3", 1'b0, 32'd8);
    @(negedge clk);
    checkFetch("stl4", 1'b0, 32'd8);
    applyStimulus(1'b0, 1'b0, 32'd0);
    #1;
    checkHead("rel0", 1'b1, 32'd0, 1'b0);
    @(negedge clk);
    checkFetch("rel1", 1'b1, 32'd8);
    checkHead("rel1", 1'b1, 32'd4, 1'b0);
    @(negedge clk);
    checkFetch("rel2", 1'b1, 32'd12);
    checkHead("rel2", 1'b1, 32'd8, 1'b0);

    // Ack delayed by 3 cycles: address held, if_en once every 4 cycles.
    ack_delay = 3;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkFetch($sformatf("dly%0d", k), 1'b1, 32'd12 + 32'd4 * 32'((k + 1) / 4));
      if (k % 4 == 3) checkHead($sformatf("dly%0d", k), 1'b1, 32'd12 + 32'd4 * 32'(k / 4), 1'b0);
      else checkHead($sformatf("dly%0d", k), 1'b0, 32'd0, 1'b1);
    end

    // Redirect while the request to 0x14 still waits for its ack.
    applyStimulus(1'b0, 1'b1, 32'h100);
    #1;
    checkOutput("drn_en", {31'd0, if_en}, 32'd0);
    @(negedge clk);
    checkFetch("drn0", 1'b1, 32'h14);
    checkHead("drn0", 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'd0);
    @(negedge clk);
    checkFetch("drn1", 1'b1, 32'h14);
    @(negedge clk);
    checkFetch("drn2", 1'b1, 32'h14);
    checkOutput("drn2_ack", {31'd0, imem.imem_ack}, 32'd1);
    @(negedge clk);
    checkFetch("drn3", 1'b1, 32'h100);
    checkHead("drn3", 1'b0, 32'd0, 1'b1);
    ack_delay = 0;
    @(negedge clk);
    checkHead("drn4", 1'b1, 32'h100, 1'b0);

    // Redirect in the same cycle as an ack that would fill the buffer.
    applyStimulus(1'b1, 1'b1, 32'h200);
    #1;
    checkOutput("rda_en", {31'd0, if_en}, 32'd0);
    @(negedge clk);
    checkFetch("rda0", 1'b1, 32'h200);
    checkHead("rda0", 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'd0);
    @(negedge clk);
    checkFetch("rda1", 1'b1, 32'h204);
    checkHead("rda1", 1'b1, 32'h200, 1'b0);

    // Fill to FULL, then redirect out of FULL with two entries held.
    applyStimulus(1'b1, 1'b0, 32'd0);
    @(negedge clk);
    checkFetch("rdf0", 1'b0, 32'h208);
    checkHead("rdf0", 1'b0, 32'h200, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h300);
    #1;
    checkOutput("rdf_en", {31'd0, if_en}, 32'd0);
    @(negedge clk);
    checkFetch("rdf1", 1'b1, 32'h300);
    checkHead("rdf1", 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'd0);
    @(negedge clk);
    checkHead("rdf2", 1'b1, 32'h300, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
